// File: rtl/acc_pkg.sv
// acc_pkg -- shared definitions for the accumulator machine controller.
// Holds the opcode encodings (IR[15:12]) and the controller state enumeration.
package acc_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_JZ    = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'h7;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        READI  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // True for the opcodes that need a memory operand and a write-back cycle.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/acc_alu.sv
// acc_alu -- combinational accumulator datapath.
// Ports:
//   op_i      opcode (IR[15:12])
//   acc_i     current accumulator
//   mdr_i     memory operand
//   result_o  new accumulator: MDR (LOAD), ACC+MDR (ADD), ACC-MDR (SUB), else ACC
//   zero_o    result_o == 0
// Arithmetic is modulo 2^16; carry and borrow are dropped.
module acc_alu
    import acc_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [15:0] acc_i,
    input  logic [15:0] mdr_i,
    output logic [15:0] result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = acc_i;
        case (op_i)
            OP_LOAD: result_o = mdr_i;
            OP_ADD:  result_o = acc_i + mdr_i;
            OP_SUB:  result_o = acc_i - mdr_i;
            default: result_o = acc_i;
        endcase
    end

    assign zero_o = (result_o == 16'h0000);

endmodule

// File: rtl/acc_control.sv
// acc_control -- control unit of a small accumulator machine.
// The register file lives outside; this block reads the current values
// (*_reg) and drives combinational next values (*_next) back into it.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   PC/IR/ACC/MDR/MAR/Zflag  _reg inputs (current), _next outputs (next)
//   mem_addr                 memory address (= MAR_reg)
//   mem_rdata                asynchronous read data for mem_addr
//   mem_wdata                write data (= ACC_reg)
//   mem_we                   write strobe, write happens at the clk edge
//   halted                   high while in HALT
//   dbg_state_o              current controller state, for observation
// Sequence: FETCH -> READI -> DECODE -> EXEC [-> WB] -> FETCH, or EXEC -> HALT.
module acc_control
    import acc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  PC_reg,
    input  logic [15:0] IR_reg,
    input  logic [15:0] ACC_reg,
    input  logic [15:0] MDR_reg,
    input  logic [7:0]  MAR_reg,
    input  logic        Zflag_reg,
    output logic [7:0]  PC_next,
    output logic [15:0] IR_next,
    output logic [15:0] ACC_next,
    output logic [15:0] MDR_next,
    output logic [7:0]  MAR_next,
    output logic        Zflag_next,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        halted,
    output state_t      dbg_state_o
);

    state_t      state_q;
    logic [3:0]  opcode;
    logic [15:0] alu_result;
    logic        alu_zero;

    assign opcode = IR_reg[15:12];

    acc_alu u_alu (
        .op_i     (opcode),
        .acc_i    (ACC_reg),
        .mdr_i    (MDR_reg),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:  state_q <= READI;
                READI:  state_q <= DECODE;
                DECODE: state_q <= EXEC;
                EXEC: begin
                    if (is_alu_op(opcode))    state_q <= WB;
                    else if (opcode == OP_HALT) state_q <= HALT;
                    else                      state_q <= FETCH;
                end
                WB:     state_q <= FETCH;
                HALT:   state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        PC_next    = PC_reg;
        IR_next    = IR_reg;
        ACC_next   = ACC_reg;
        MDR_next   = MDR_reg;
        MAR_next   = MAR_reg;
        Zflag_next = Zflag_reg;
        mem_we     = 1'b0;
        case (state_q)
            FETCH:  MAR_next = PC_reg;
            READI: begin
                MDR_next = mem_rdata;
                PC_next  = PC_reg + 8'd1;
            end
            DECODE: begin
                IR_next  = MDR_reg;
                MAR_next = MDR_reg[7:0];
            end
            EXEC: begin
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUB: MDR_next = mem_rdata;
                    // Reset wins so a STORE interrupted by rst never writes.
                    OP_STORE: mem_we = ~rst;
                    OP_JMP:   PC_next = IR_reg[7:0];
                    OP_JZ:    if (Zflag_reg) PC_next = IR_reg[7:0];
                    default:  ;
                endcase
            end
            WB: begin
                ACC_next   = alu_result;
                Zflag_next = alu_zero;
            end
            default: ;
        endcase
    end

    assign mem_addr    = MAR_reg;
    assign mem_wdata   = ACC_reg;
    assign halted      = (state_q == HALT) && !rst;
    assign dbg_state_o = state_q;

endmodule

// File: doc/acc_control.md
ACC_CONTROL -- requirements
Module: acc_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous active-high reset; sampled on the clk rising edge.
REQ-003 PC_reg/IR_reg/ACC_reg/MDR_reg/MAR_reg/Zflag_reg  input  8/16/16/16/8/1  current register-file values.
REQ-004 PC_next/IR_next/ACC_next/MDR_next/MAR_next/Zflag_next  output  8/16/16/16/8/1  combinational next values driven into the register file.
REQ-005 mem_addr  output  8  memory address; always equals MAR_reg.
REQ-006 mem_rdata  input  16  asynchronous-read memory data for mem_addr, valid in the same cycle.
REQ-007 mem_wdata  output  16  write data; always equals ACC_reg.
REQ-008 mem_we  output  1  memory write strobe; write occurs at the clk edge where mem_we=1.
REQ-009 halted  output  1  high while in state HALT.

Function
REQ-010 Instruction format: opcode=IR[15:12], operand address=IR[7:0], IR[11:8] ignored.
REQ-011 Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 JMP, 6 JZ, 7 HALT; 8-15 SHALL execute as NOP.
REQ-012 Default: every *_next output SHALL equal its *_reg input unless a state below overrides it; mem_we defaults to 0.
REQ-013 FETCH: MAR_next=PC_reg; next state READI.
REQ-014 READI: MDR_next=mem_rdata; PC_next=PC_reg+1 modulo 256 (0xFF wraps to 0x00); next state DECODE.
REQ-015 DECODE: IR_next=MDR_reg; MAR_next=MDR_reg[7:0]; next state EXEC.
REQ-016 EXEC LOAD/ADD/SUB: MDR_next=mem_rdata; next state WB.
REQ-017 EXEC STORE: mem_we=1; next state FETCH.
REQ-018 EXEC JMP: PC_next=IR_reg[7:0]; next state FETCH.
REQ-019 EXEC JZ: PC_next=IR_reg[7:0] if Zflag_reg=1, else PC unchanged; next state FETCH.
REQ-020 EXEC NOP/undefined: no register change; next state FETCH.
REQ-021 EXEC HALT: next state HALT.
REQ-022 WB: ACC_next = MDR_reg (LOAD), ACC_reg+MDR_reg (ADD), or ACC_reg-MDR_reg (SUB), all modulo 2^16, carry/borrow discarded; Zflag_next=(ACC_next==0); next state FETCH.
REQ-023 Zflag SHALL change only in WB; STORE/JMP/JZ/NOP leave it unchanged.
REQ-024 HALT: all *_next hold, mem_we=0, halted=1; state remains HALT until rst.
REQ-025 Latency, FETCH entry to next FETCH: LOAD/ADD/SUB 5 cycles; all others 4 cycles.

Reset
REQ-026 On rst the state register SHALL go to FETCH at the same edge, regardless of current state (including HALT and mid-instruction).
REQ-027 While rst=1, mem_we SHALL be 0 and halted SHALL be 0; the register file clears itself, so no partial STORE may complete.
REQ-028 First cycle after rst deasserts SHALL be FETCH with PC_reg=0.

Structure
REQ-029 A shared package acc_pkg SHALL hold the opcode constants and the state enumeration (FETCH, READI, DECODE, EXEC, WB, HALT).
REQ-030 One combinational sub-module acc_alu SHALL compute the LOAD/ADD/SUB result and zero flag; the FSM and next-value muxing stay in acc_control.

Verification
REQ-031 Memory[0]=0x1010, [0x10]=0x0005; run from reset -> after 5 cycles ACC=0x0005, Zflag=0, PC=0x01.
REQ-032 ACC=0x0005, instr SUB 0x11 with [0x11]=0x0005 -> ACC=0x0000, Zflag=1; following JZ 0x40 -> PC=0x40 after 4 cycles; with Zflag=0 PC simply increments.
REQ-033 ACC=0xFFFF, ADD of 0x0002 -> ACC=0x0001, Zflag=0 (wrap); STORE 0x20 -> memory[0x20]=0x0001, mem_we high exactly one cycle.
REQ-034 PC=0xFF fetching a NOP (or opcode 0xA) -> PC=0x00, no other register changes.
REQ-035 HALT executed -> halted=1, registers frozen for 20 cycles; rst asserted mid-HALT and mid-STORE EXEC -> no write, state FETCH, PC=0 next cycle.
